// File: rtl/fetch_stage.sv
// Instruction fetch stage: holds the PC, issues one word-aligned request at a time
// to instruction memory and captures the returned word into the IF/ID register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_DRAIN,
    S_HALT
  } state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        id_valid_q;
  logic [31:0] id_instr_q;
  logic [31:0] id_pc_q;
  logic        fault_q;

  logic        req_fire;
  logic        redirect_misaligned;
  logic [31:0] pc_inc_d;

  // A slot opens when the IF/ID register is empty or is being consumed this cycle.
  assign imem_req_valid      = !rst && (state_q == S_FETCH) && !redirect_valid &&
                               (!id_valid_q || id_ready);
  assign req_fire            = imem_req_valid && imem_req_ready;
  assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);
  assign pc_inc_d            = pc_q + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      id_valid_q <= 1'b0;
      id_instr_q <= NOP_INSTR;
      id_pc_q    <= 32'h0000_0000;
      fault_q    <= 1'b0;
    end else if (state_q != S_HALT && redirect_valid) begin
      id_valid_q <= 1'b0;
      if (redirect_misaligned) begin
        fault_q <= 1'b1;
        state_q <= S_HALT;
      end else begin
        pc_q <= redirect_pc;
        // An in-flight request becomes stale; a response arriving now is the stale one.
        if (state_q == S_WAIT || state_q == S_DRAIN) begin
          state_q <= imem_resp_valid ? S_FETCH : S_DRAIN;
        end
      end
    end else begin
      // NOTE: non-blocking assignments let a later write in this block (a captured
      // response) override the consumption clear below without ordering hazards.
      if (id_valid_q && id_ready) id_valid_q <= 1'b0;
      unique case (state_q)
        S_FETCH: begin
          if (req_fire) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            id_instr_q <= imem_resp_data;
            id_pc_q    <= pc_q;
            id_valid_q <= 1'b1;
            pc_q       <= pc_inc_d;
            state_q    <= S_FETCH;
          end
        end
        S_DRAIN: begin
          if (imem_resp_valid) state_q <= S_FETCH;
        end
        S_HALT: begin
          id_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_addr = pc_q;
  assign id_valid      = id_valid_q;
  assign id_instr      = id_instr_q;
  assign id_pc         = id_pc_q;
  assign fetch_fault   = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic,
// all checked against a transaction-level reference model and a latency memory model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;

  logic        imem_req_valid, id_valid, fetch_fault;
  logic [31:0] imem_req_addr, id_instr, id_pc;
  logic        req_valid_w, id_valid_w, fault_w;
  logic [31:0] req_addr_w, id_instr_w, id_pc_w;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .fetch_fault(fetch_fault)
  );

  // Second instance shares all stimulus; only its PC sequence is inspected (wrap case).
  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid_w), .imem_req_ready(imem_req_ready),
    .imem_req_addr(req_addr_w),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid_w), .id_ready(id_ready), .id_instr(id_instr_w), .id_pc(id_pc_w),
    .fetch_fault(fault_w)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Memory model: one outstanding request, fixed latency chosen at handshake.
  int          mem_lat = 1;
  bit          mem_busy = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = '0;

  // Reference model of the fetch stage's architectural behaviour.
  bit          m_known = 1'b0;
  logic [31:0] m_pc, m_instr, m_idpc;
  bit          m_out, m_stale, m_halt, m_idv, m_fault;

  // Per-cycle samples and logs.
  logic        s_req, s_hs, s_idv;
  logic [31:0] s_addr;
  logic [31:0] cons_q[$], cons_i_q[$], cons_w_q[$], req_q[$];
  int          cons_t_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_update(input bit hs);
    if (rst) begin
      m_known = 1'b1; m_pc = 32'h0; m_out = 1'b0; m_stale = 1'b0; m_halt = 1'b0;
      m_idv = 1'b0; m_instr = 32'h0000_0013; m_idpc = 32'h0; m_fault = 1'b0;
    end else if (m_known && !m_halt) begin
      if (redirect_valid && redirect_pc[1:0] != 2'b00) begin
        m_fault = 1'b1; m_halt = 1'b1; m_idv = 1'b0;
      end else if (redirect_valid) begin
        m_pc  = redirect_pc;
        m_idv = 1'b0;
        if (m_out && imem_resp_valid) begin
          m_out = 1'b0; m_stale = 1'b0;
        end else if (m_out) begin
          m_stale = 1'b1;
        end
      end else begin
        if (m_idv && id_ready) m_idv = 1'b0;
        if (m_out && imem_resp_valid) begin
          if (!m_stale) begin
            m_idv = 1'b1; m_instr = imem_resp_data; m_idpc = m_pc; m_pc = m_pc + 32'd4;
          end
          m_out = 1'b0; m_stale = 1'b0;
        end
        if (hs) m_out = 1'b1;
      end
    end
  endtask

  // One clock cycle: called at posedge+1 with inputs already set by the caller.
  task automatic cycle();
    bit exp_req;
    if (mem_busy) mem_cnt--;
    imem_resp_valid = mem_busy && (mem_cnt == 0);
    imem_resp_data  = imem_resp_valid ? (mem_addr ^ 32'hA5A5_0000) : $urandom;
    #4;
    exp_req = !rst && m_known && !m_halt && !m_out && !redirect_valid && (!m_idv || id_ready);
    check("req_valid", imem_req_valid, exp_req);
    if (m_known) begin
      check("req_addr", imem_req_addr, m_pc);
      check("id_valid", id_valid, m_idv);
      check("id_instr", id_instr, m_instr);
      check("id_pc", id_pc, m_idpc);
      check("fetch_fault", fetch_fault, m_fault);
    end
    s_req  = imem_req_valid;
    s_addr = imem_req_addr;
    s_idv  = id_valid;
    s_hs   = imem_req_valid && imem_req_ready;
    if (s_hs) req_q.push_back(imem_req_addr);
    if (id_valid && id_ready) begin
      cons_q.push_back(id_pc);
      cons_i_q.push_back(id_instr);
      cons_t_q.push_back(cyc);
    end
    if (id_valid_w && id_ready) cons_w_q.push_back(id_pc_w);
    model_update(exp_req && imem_req_ready);
    if (rst) begin
      mem_busy = 1'b0;
    end else begin
      if (imem_resp_valid) mem_busy = 1'b0;
      if (s_hs) begin
        mem_busy = 1'b1; mem_cnt = mem_lat; mem_addr = imem_req_addr;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    cons_q.delete(); cons_i_q.delete(); cons_w_q.delete(); req_q.delete(); cons_t_q.delete();
  endtask

  task automatic run_until_cons(input int n, input int budget, input string tag);
    int i = 0;
    while (cons_q.size() < n && i < budget) begin
      cycle();
      i++;
    end
    check(tag, cons_q.size() >= n, 1'b1);
  endtask

  initial begin
    int i;
    rst = 1'b1; imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
    @(posedge clk);
    #1;

    // Sequential fetch, 1-cycle memory, decode always ready; includes PC wrap instance.
    clear_logs();
    do_reset();
    check("reset_req_low", s_req, 1'b0);
    run_until_cons(4, 40, "seq_progress");
    for (int k = 0; k < 4; k++) begin
      check("seq_pc", cons_q[k], 32'(k * 4));
      check("seq_instr", cons_i_q[k], 32'(k * 4) ^ 32'hA5A5_0000);
    end
    check("seq_rate", cons_t_q[3] - cons_t_q[0], 32'd6);
    check("wrap_pc0", cons_w_q[0], 32'hFFFF_FFFC);
    check("wrap_pc1", cons_w_q[1], 32'h0000_0000);

    // Back-pressure: decode stalls after the first instruction arrives.
    clear_logs();
    do_reset();
    id_ready = 1'b0;
    i = 0;
    do begin cycle(); i++; end while (!s_idv && i < 10);
    check("bp_first_valid", s_idv, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("bp_pc", id_pc, 32'h0);
      check("bp_instr", id_instr, 32'hA5A5_0000);
      check("bp_no_req", s_req, 1'b0);
    end
    check("bp_one_req", req_q.size(), 32'd1);
    id_ready = 1'b1;
    run_until_cons(2, 20, "bp_progress");
    check("bp_pc0", cons_q[0], 32'h0);
    check("bp_pc1", cons_q[1], 32'h4);

    // Redirect one cycle after the handshake for PC 8, 3-cycle memory.
    clear_logs();
    do_reset();
    mem_lat = 3;
    i = 0;
    do begin cycle(); i++; end while (!(s_hs && s_addr == 32'h8) && i < 40);
    check("wait_hs8", s_hs && s_addr == 32'h8, 1'b1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    cycle();
    redirect_valid = 1'b0;
    clear_logs();
    run_until_cons(1, 30, "drain_progress");
    check("drain_req_addr", req_q[0], 32'h100);
    check("drain_id_pc", cons_q[0], 32'h100);

    // Redirect in the same cycle as a response.
    mem_lat = 1;
    i = 0;
    do begin cycle(); i++; end while (!s_hs && i < 20);
    check("rr_hs_seen", s_hs, 1'b1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    check("rr_id_valid", s_idv, 1'b0);
    check("rr_req", s_req, 1'b1);
    check("rr_addr", s_addr, 32'h40);

    // Flush of a held IF/ID entry even though decode is ready.
    id_ready = 1'b0;
    i = 0;
    do begin cycle(); i++; end while (!s_idv && i < 20);
    check("flush_held", s_idv, 1'b1);
    id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0080;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    check("flush_id_valid", s_idv, 1'b0);
    check("flush_addr", s_addr, 32'h80);

    // Misaligned redirect: sticky fault, halt, aligned redirects ignored.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    cycle();
    redirect_valid = 1'b0;
    check("fault_set", fetch_fault, 1'b1);
    clear_logs();
    repeat (5) cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0080;
    cycle();
    redirect_valid = 1'b0;
    repeat (5) cycle();
    check("halt_no_req", req_q.size(), 32'd0);
    check("halt_fault", fetch_fault, 1'b1);
    check("halt_id_valid", id_valid, 1'b0);
    do_reset();
    check("fault_clear", fetch_fault, 1'b0);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 3000; k++) begin
      rst            = ($urandom_range(0, 149) == 0);
      id_ready       = ($urandom_range(0, 3) != 0);
      imem_req_ready = ($urandom_range(0, 2) != 0);
      mem_lat        = $urandom_range(1, 4);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 59) == 0) redirect_pc = redirect_pc | 32'h2;
      cycle();
    end
    rst = 1'b0; redirect_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
